lcd_cmd_issuer: RTL and testbench

- Command front-end sitting directly upstream of the LCD controller.
- Host pushes 4-bit LCD commands into a small FIFO at its own pace. The block issues each command to the LCD controller on its cmd/cmd_valid interface, honouring the controller's busy handshake.
- After issuing the write command (cmd 0), it waits for the controller's done and reports sequence completion.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_cmd_fifo.sv | 71 +++++++
 rtl/lcd_cmd_issuer.sv | 163 ++++++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD command path:
//   - 4-bit LCD controller command encodings
//   - state encoding of the lcd_cmd_issuer sequencing FSM
//   - helper to recognise the image-write command
// -----------------------------------------------------------------------------
package lcd_pkg;

    // LCD controller command encodings
    localparam logic [3:0] CMD_WRITE     = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP  = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DN  = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LT  = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RT  = 4'd4;
    localparam logic [3:0] CMD_MAX       = 4'd5;
    localparam logic [3:0] CMD_MIN       = 4'd6;
    localparam logic [3:0] CMD_AVG       = 4'd7;
    localparam logic [3:0] CMD_ROT_CW    = 4'd8;
    localparam logic [3:0] CMD_ROT_CCW   = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X  = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y  = 4'd11;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBusy,
        StWaitReady,
        StWaitDone,
        StFinish
    } issuer_state_e;

    // The write command ends the sequence: no busy handshake, wait for done.
    function automatic logic is_write_cmd(input logic [3:0] c);
        return c == CMD_WRITE;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// -----------------------------------------------------------------------------
// lcd_cmd_fifo
// Circular command buffer, DEPTH entries of 4 bits, registered (no fall-through).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears pointers/data)
//   i_push, i_data  enqueue request and data (ignored when full)
//   i_pop           dequeue request (ignored when empty)
//   o_head          entry at the read pointer
//   o_count         occupancy 0..DEPTH
//   o_full, o_empty occupancy flags
// -----------------------------------------------------------------------------
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [3:0]        i_data,
    input  logic              i_pop,
    output logic [3:0]        o_head,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [3:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == FullCount);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // A push on a full buffer is refused even when a pop happens the same cycle.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                // DEPTH is a power of two, so the pointer wraps naturally.
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// -----------------------------------------------------------------------------
// lcd_cmd_issuer
// Buffers host LCD commands and issues them one at a time to the LCD
// controller, honouring its busy handshake. The write command (0) ends the
// sequence: after done the block parks in a terminal state until reset.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   host_cmd, host_push   host enqueue interface
//   fifo_full, fifo_count buffer status
//   cmd, cmd_valid        registered command and one-cycle issue strobe
//   busy, done            LCD controller status
//   seq_done              sticky: write issued and done observed
//   err_drop              sticky: a host push was discarded
//   err_stall             sticky: busy did not rise within BUSY_WAIT cycles
// -----------------------------------------------------------------------------
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned BUSY_WAIT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      host_cmd,
    input  logic            host_push,
    output logic            fifo_full,
    output logic [ADDR_W:0] fifo_count,
    output logic [3:0]      cmd,
    output logic            cmd_valid,
    input  logic            busy,
    input  logic            done,
    output logic            seq_done,
    output logic            err_drop,
    output logic            err_stall
);

    // Counter runs 0..BUSY_WAIT-1; reaching the last value without busy is a stall.
    localparam int unsigned WcntW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [WcntW-1:0] WcntLast = WcntW'(BUSY_WAIT - 1);

    issuer_state_e    r_state;
    issuer_state_e    w_state_d;
    logic [WcntW-1:0] r_wait_cnt;
    logic [WcntW-1:0] w_wait_cnt_d;
    logic [3:0]       r_cmd;
    logic [3:0]       w_cmd_d;
    logic             r_cmd_valid;
    logic             w_cmd_valid_d;
    logic             r_seq_done;
    logic             w_seq_done_d;
    logic             r_err_drop;
    logic             w_err_drop_d;
    logic             r_err_stall;
    logic             w_err_stall_d;

    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_head;
    logic             w_full;
    logic             w_empty;

    // Host pushes are refused when full or once the sequence has finished.
    assign w_push = host_push & ~w_full & (r_state != StFinish);

    lcd_cmd_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (host_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_d     = r_state;
        w_wait_cnt_d  = r_wait_cnt;
        w_cmd_d       = r_cmd;
        w_cmd_valid_d = 1'b0;
        w_pop         = 1'b0;
        w_seq_done_d  = r_seq_done;
        w_err_stall_d = r_err_stall;
        w_err_drop_d  = r_err_drop | (host_push & ~w_push);

        unique case (r_state)
            StIdle: begin
                // Busy high (e.g. initial image load) holds the head in place.
                if (!w_empty && !busy) begin
                    w_pop         = 1'b1;
                    w_cmd_d       = w_head;
                    w_cmd_valid_d = 1'b1;
                    if (is_write_cmd(w_head)) begin
                        w_state_d = StWaitDone;
                    end else begin
                        w_state_d    = StWaitBusy;
                        w_wait_cnt_d = '0;
                    end
                end
            end
            StWaitBusy: begin
                if (busy) begin
                    w_state_d = StWaitReady;
                end else if (r_wait_cnt == WcntLast) begin
                    w_err_stall_d = 1'b1;
                    w_state_d     = StIdle;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 1'b1;
                end
            end
            StWaitReady: begin
                if (!busy) begin
                    w_state_d = StIdle;
                end
            end
            StWaitDone: begin
                if (done) begin
                    w_seq_done_d = 1'b1;
                    w_state_d    = StFinish;
                end
            end
            StFinish: begin
                w_state_d = StFinish;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_seq_done  <= 1'b0;
            r_err_drop  <= 1'b0;
            r_err_stall <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_cmd       <= w_cmd_d;
            r_cmd_valid <= w_cmd_valid_d;
            r_seq_done  <= w_seq_done_d;
            r_err_drop  <= w_err_drop_d;
            r_err_stall <= w_err_stall_d;
        end
    end

    assign cmd       = r_cmd;
    assign cmd_valid = r_cmd_valid;
    assign fifo_full = w_full;
    assign seq_done  = r_seq_done;
    assign err_drop  = r_err_drop;
    assign err_stall = r_err_stall;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_lcd_cmd_issuer
// Directed bench for lcd_cmd_issuer. Accepted pushes put the expected command
// into a queue; a monitor pops and compares on every cmd_valid. A small
// controller model raises busy for 3 cycles one cycle after each non-write
// issue, and pulses done 5 cycles after the write command.
// -----------------------------------------------------------------------------
module tb_lcd_cmd_issuer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned BUSY_WAIT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      host_cmd;
    logic            host_push;
    logic            fifo_full;
    logic [ADDR_W:0] fifo_count;
    logic [3:0]      cmd;
    logic            cmd_valid;
    logic            busy;
    logic            done;
    logic            seq_done;
    logic            err_drop;
    logic            err_stall;

    logic            busy_manual;
    logic            busy_auto   = 1'b0;
    logic            done_auto   = 1'b0;
    logic            auto_en     = 1'b0;
    logic [3:0]      ignore_cmd  = 4'hF;
    logic            start_next  = 1'b0;
    int              busy_left   = 0;
    int              done_left   = 0;

    int              checks      = 0;
    int              errors      = 0;
    int              n_issued    = 0;
    logic            prev_valid  = 1'b0;
    logic [3:0]      exp_q[$];

    assign busy = busy_manual | busy_auto;
    assign done = done_auto;

    always #5 clk = ~clk;

    lcd_cmd_issuer #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_push  (host_push),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .seq_done   (seq_done),
        .err_drop   (err_drop),
        .err_stall  (err_stall)
    );

    // Controller model, acting just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            busy_auto  = 1'b0;
            done_auto  = 1'b0;
            start_next = 1'b0;
            busy_left  = 0;
            done_left  = 0;
        end else begin
            done_auto = 1'b0;
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) done_auto = 1'b1;
            end
            if (start_next) begin
                busy_auto  = 1'b1;
                busy_left  = 3;
                start_next = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) busy_auto = 1'b0;
            end
            if (auto_en && cmd_valid) begin
                if (cmd == 4'd0) done_left = 5;
                else if (cmd != ignore_cmd) start_next = 1'b1;
            end
        end
    end

    // Monitor: every issue strobe is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (cmd_valid) begin
                n_issued++;
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL strobe_width: cmd_valid high on consecutive cycles, required one cycle");
                end
                checks++;
                if (busy) begin
                    errors++;
                    $display("FAIL issue_while_busy: busy=1 at issue of cmd=%0d, required busy=0", cmd);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got cmd=%0d, required no issue", cmd);
                end else begin
                    logic [3:0] exp;
                    exp = exp_q.pop_front();
                    if (cmd !== exp) begin
                        errors++;
                        $display("FAIL issue_order: got cmd=%0d, required cmd=%0d", cmd, exp);
                    end
                end
            end
            prev_valid = cmd_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input bit accept);
        host_cmd  = c;
        host_push = 1'b1;
        if (accept) exp_q.push_back(c);
        step();
        host_push = 1'b0;
    endtask

    task automatic wait_issued(input int target, input int budget, input string name);
        int k = 0;
        while (n_issued < target && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (n_issued < target) begin
            errors++;
            $display("FAIL %s: issued %0d commands, required %0d", name, n_issued, target);
        end
    endtask

    initial begin
        int base;
        int k;
        reset       = 1'b0;
        host_cmd    = 4'd0;
        host_push   = 1'b0;
        busy_manual = 1'b1;
        step();
        step();

        // Reset values
        check("rst_cmd", 32'(cmd), 0);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_fifo_full", 32'(fifo_full), 0);
        check("rst_seq_done", 32'(seq_done), 0);
        check("rst_err_drop", 32'(err_drop), 0);
        check("rst_err_stall", 32'(err_stall), 0);

        // Busy held high after reset: commands queue but are not issued
        reset = 1'b1;
        step();
        push(4'd1, 1'b1);
        push(4'd2, 1'b1);
        push(4'd0, 1'b1);
        check("t1_count_queued", 32'(fifo_count), 3);
        repeat (64) step();
        check("t1_no_issue_while_busy", 32'(n_issued), 0);
        check("t1_count_held", 32'(fifo_count), 3);
        check("t1_err_drop_clear", 32'(err_drop), 0);
        busy_manual = 1'b0;
        auto_en     = 1'b1;
        step();
        check("t1_first_valid", 32'(cmd_valid), 1);
        check("t1_first_cmd", 32'(cmd), 1);
        check("t1_count_after_pop", 32'(fifo_count), 2);
        step();
        check("t1_valid_one_cycle", 32'(cmd_valid), 0);
        check("t1_cmd_holds", 32'(cmd), 1);

        // Handshaked issue of 2 then write, done completes the sequence
        wait_issued(3, 60, "t2_drain");
        k = 0;
        while (!seq_done && k < 40) begin
            step();
            k++;
        end
        check("t2_seq_done", 32'(seq_done), 1);
        check("t2_count_empty", 32'(fifo_count), 0);
        push(4'd7, 1'b0);
        check("t2_finish_drop_flag", 32'(err_drop), 1);
        check("t2_finish_count_frozen", 32'(fifo_count), 0);
        repeat (10) step();
        check("t2_finish_no_issue", 32'(n_issued), 3);
        check("t2_seq_done_sticky", 32'(seq_done), 1);

        // Overfill: 9 pushes while busy, the 9th is dropped
        auto_en     = 1'b0;
        busy_manual = 1'b1;
        reset       = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("t3_seq_done_cleared", 32'(seq_done), 0);
        check("t3_err_drop_cleared", 32'(err_drop), 0);
        step();
        for (int i = 1; i <= 8; i++) push(4'(i), 1'b1);
        check("t3_count_8", 32'(fifo_count), 8);
        check("t3_full", 32'(fifo_full), 1);
        check("t3_no_drop_yet", 32'(err_drop), 0);
        push(4'd9, 1'b0);
        check("t3_drop_flag", 32'(err_drop), 1);
        check("t3_count_capped", 32'(fifo_count), 8);
        base        = n_issued;
        busy_manual = 1'b0;
        auto_en     = 1'b1;
        wait_issued(base + 8, 150, "t3_drain");
        repeat (8) step();
        check("t3_drained_count", 32'(fifo_count), 0);
        check("t3_drained_full", 32'(fifo_full), 0);

        // Push and pop in the same cycle with three entries queued
        busy_manual = 1'b1;
        push(4'd10, 1'b1);
        push(4'd11, 1'b1);
        push(4'd3, 1'b1);
        check("t4_count_3", 32'(fifo_count), 3);
        base        = n_issued;
        host_cmd    = 4'd4;
        host_push   = 1'b1;
        busy_manual = 1'b0;
        exp_q.push_back(4'd4);
        step();
        host_push = 1'b0;
        check("t4_count_push_pop", 32'(fifo_count), 3);
        check("t4_issue_valid", 32'(cmd_valid), 1);
        wait_issued(base + 4, 80, "t4_drain");
        repeat (8) step();

        // Controller ignores cmd 5: stall flagged after two cycles
        check("t5_stall_clear", 32'(err_stall), 0);
        ignore_cmd = 4'd5;
        push(4'd5, 1'b1);
        push(4'd6, 1'b1);
        check("t5_issue5_valid", 32'(cmd_valid), 1);
        check("t5_issue5_cmd", 32'(cmd), 5);
        step();
        check("t5_stall_not_yet", 32'(err_stall), 0);
        step();
        check("t5_stall_set", 32'(err_stall), 1);
        check("t5_gap_valid", 32'(cmd_valid), 0);
        step();
        check("t5_next_valid", 32'(cmd_valid), 1);
        check("t5_next_cmd", 32'(cmd), 6);
        repeat (10) step();
        ignore_cmd = 4'hF;

        // Asynchronous reset while waiting for busy to fall
        busy_manual = 1'b1;
        push(4'd1, 1'b1);
        push(4'd2, 1'b1);
        push(4'd3, 1'b1);
        push(4'd4, 1'b1);
        push(4'd7, 1'b1);
        check("t6_count_5", 32'(fifo_count), 5);
        busy_manual = 1'b0;
        step();
        check("t6_count_4", 32'(fifo_count), 4);
        step();
        step();
        check("t6_pre_count", 32'(fifo_count), 4);
        check("t6_pre_err_drop", 32'(err_drop), 1);
        check("t6_pre_err_stall", 32'(err_stall), 1);
        reset = 1'b0;
        #1;
        check("t6_rst_cmd", 32'(cmd), 0);
        check("t6_rst_cmd_valid", 32'(cmd_valid), 0);
        check("t6_rst_count", 32'(fifo_count), 0);
        check("t6_rst_full", 32'(fifo_full), 0);
        check("t6_rst_err_drop", 32'(err_drop), 0);
        check("t6_rst_err_stall", 32'(err_stall), 0);
        check("t6_rst_seq_done", 32'(seq_done), 0);
        exp_q.delete();
        step();
        step();
        reset = 1'b1;
        step();
        base = n_issued;
        push(4'd3, 1'b1);
        wait_issued(base + 1, 20, "t6_resume");
        repeat (5) step();
        check("t6_final_count", 32'(fifo_count), 0);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
